merlin_mem_arbiter: RTL and testbench
=====================================

Name: merlin_mem_arbiter

Overview:
- Merges the core's instruction port and data port onto one unified memory port, for single-ported memory systems.
- Request and data widths are parametrised (bus width set by C_BUS_SZX).
- Up to 2**C_OSTD_DEPTH_X accepted requests may be outstanding; an in-order route FIFO steers each response back to the port that issued it.
- Sits between the core top-level and the memory/interconnect.

Parameters:
- C_BUS_SZX, 5: bus data width = 2**C_BUS_SZX bits (C_BUS_SZX >= 3).
- C_ADDR_SZ, 32: address width.
- C_OSTD_DEPTH_X, 2: route FIFO depth = 2**C_OSTD_DEPTH_X outstanding requests.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- ireqready_o  out  1  instruction request accepted
- ireqvalid_i  in  1  instruction request valid
- ireqhpl_i  in  2  instruction hart privilege level
- ireqaddr_i  in  C_ADDR_SZ  instruction address
- irspready_i  in  1  instruction response consumer ready
- irspvalid_o  out  1  instruction response valid
- irsprerr_o  out  1  instruction read error
- irspdata_o  out  2**C_BUS_SZX  instruction read data
- dreqready_o  out  1  data request accepted
- dreqvalid_i  in  1  data request valid
- dreqsize_i  in  2  log2 access bytes
- dreqdvalid_i  in  1  write (1) / read (0)
- dreqhpl_i  in  2  data hart privilege level
- dreqaddr_i  in  C_ADDR_SZ  data address
- dreqdata_i  in  2**C_BUS_SZX  write data
- drspready_i  in  1  data response consumer ready
- drspvalid_o  out  1  data response valid
- drsprerr_o  out  1  data read error
- drspwerr_o  out  1  data write error
- drspdata_o  out  2**C_BUS_SZX  data read data
- mreqready_i  in  1  memory accepts request
- mreqvalid_o  out  1  memory request valid
- mreqsrc_o  out  1  request source: 0 = instruction, 1 = data
- mreqsize_o  out  2  access size
- mreqdvalid_o  out  1  write flag
- mreqhpl_o  out  2  privilege level
- mreqaddr_o  out  C_ADDR_SZ  address
- mreqdata_o  out  2**C_BUS_SZX  write data
- mrspready_o  out  1  response accepted
- mrspvalid_i  in  1  memory response valid
- mrsprerr_i  in  1  read error
- mrspwerr_i  in  1  write error
- mrspdata_i  in  2**C_BUS_SZX  read data

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (reset_i).
- Reset values:
  - All outputs 0.
  - Route FIFO empty; count = 0.
  - Grant lock clear; last-grant = data (so the instruction port wins the first tie).
- Request path is combinational pass-through (0 cycles). A request is accepted when mreqvalid_o & mreqready_i.
- Arbitration, when unlocked:
  - Only one port valid: that port is granted.
  - Both ports valid: round-robin; the port not granted last wins.
  - last-grant updates only on acceptance.
- Lock:
  - If mreqvalid_o=1 and mreqready_i=0, set the lock and keep the grant until acceptance.
  - Request fields stay stable while locked; a newly valid other port cannot preempt.
- Instruction grant field mapping:
  - mreqsize_o = C_BUS_SZX-3 (full bus word).
  - mreqdvalid_o = 0.
  - mreqdata_o = 0.
  - mreqsrc_o = 0.
- Data grant: all fields copied from the data port; mreqsrc_o = 1.
- Ready: ireqready_o / dreqready_o = (granted) & mreqready_i & !full.
- Full: when count == 2**C_OSTD_DEPTH_X, mreqvalid_o = 0, both reqready = 0, and the lock is held.
- Route FIFO:
  - Push the source bit on each acceptance; pop on mrspvalid_i & mrspready_o.
  - Count is C_OSTD_DEPTH_X+1 bits; pointers wrap modulo depth.
  - Push and pop in the same cycle: count unchanged. Pop frees space only from the next cycle; full is evaluated on the registered count.
- Response path is combinational (0 cycles):
  - Head = 0: irspvalid_o = mrspvalid_i; irsprerr_o = mrsprerr_i; mrspready_o = irspready_i.
  - Head = 1: drspvalid_o / drsprerr_o / drspwerr_o follow the memory response; mrspready_o = drspready_i.
  - The non-head port's valid = 0. rspdata is broadcast to both ports.
- Empty FIFO: mrspready_o = 0; both rspvalid = 0 (unsolicited responses stall, never routed).
- Reset mid-transaction: FIFO flushed; responses to flushed requests are the system's responsibility (memory is reset together).

Optional Feature:
- Macro: MERLIN_ARB_DPRIO_EN.
- Defined: fixed priority, the data port always wins ties (keeps loads/stores ahead of prefetch); the lock rule still applies.
- Undefined: round-robin as described above.

Decomposition:
- Shared package: source-id constants (SRC_I = 0, SRC_D = 1) and the bus-width macro derived from C_BUS_SZX.
- Sub-module merlin_route_fifo: 1-bit wide, depth 2**C_OSTD_DEPTH_X, with push/pop/full/empty/head outputs.

Test Plan:
- Reset mid-flight: 2 outstanding, then reset_i pulse -> all outputs 0, FIFO empty; next ifetch is granted first.
- Both ports valid, mreqready_i = 1, 4 cycles -> grants I, D, I, D; mreqsrc_o = 0,1,0,1. With MERLIN_ARB_DPRIO_EN -> D, D, D, D.
- Data write addr 0x100, data 0xDEADBEEF, mreqready_i = 0 for 3 cycles while ireqvalid_i rises -> fields stable for 3 cycles; accepted on cycle 4; instruction granted next.
- Depth 4, 4 accepted requests with no responses -> 5th request: mreqvalid_o = 0, both reqready = 0. Response pop plus new request in the same cycle -> the new request is accepted only the following cycle.
- Accept I, D, I; responses rdata 0x11, 0x22 (werr = 1), 0x33 -> irspvalid_o carries 0x11; drspvalid_o carries 0x22 with drspwerr_o = 1; irspvalid_o carries 0x33. drspready_i = 0 stalls mrspready_o.
- mrspvalid_i = 1 with FIFO empty -> mrspready_o = 0; irspvalid_o = drspvalid_o = 0.

Source files
------------

// File: rtl/merlin_mem_arbiter_pkg.sv
// Shared definitions for the merlin memory arbiter: source ids, the grant-lock
// state encoding and the bus-width helper derived from C_BUS_SZX.
`ifndef MERLIN_BUS_W
`define MERLIN_BUS_W(szx) (1 << (szx))
`endif

package merlin_mem_arbiter_pkg;

   localparam logic SRC_I = 1'b0;
   localparam logic SRC_D = 1'b1;

   typedef enum logic [0:0] {
      ST_FREE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   function automatic int bus_w(input int szx);
      return `MERLIN_BUS_W(szx);
   endfunction

endpackage

// File: rtl/merlin_mem_arbiter_if.sv
// Bus bundle seen by the arbiter: instruction, data and unified memory ports.
// slave = arbiter side, master = core/memory side.
interface merlin_mem_arbiter_if #(
   parameter int C_BUS_SZX = 5,
   parameter int C_ADDR_SZ = 32
) ();
   import merlin_mem_arbiter_pkg::*;

   localparam int W = bus_w(C_BUS_SZX);

   logic                 ireqready_o;
   logic                 ireqvalid_i;
   logic [1:0]           ireqhpl_i;
   logic [C_ADDR_SZ-1:0] ireqaddr_i;
   logic                 irspready_i;
   logic                 irspvalid_o;
   logic                 irsprerr_o;
   logic [W-1:0]         irspdata_o;

   logic                 dreqready_o;
   logic                 dreqvalid_i;
   logic [1:0]           dreqsize_i;
   logic                 dreqdvalid_i;
   logic [1:0]           dreqhpl_i;
   logic [C_ADDR_SZ-1:0] dreqaddr_i;
   logic [W-1:0]         dreqdata_i;
   logic                 drspready_i;
   logic                 drspvalid_o;
   logic                 drsprerr_o;
   logic                 drspwerr_o;
   logic [W-1:0]         drspdata_o;

   logic                 mreqready_i;
   logic                 mreqvalid_o;
   logic                 mreqsrc_o;
   logic [1:0]           mreqsize_o;
   logic                 mreqdvalid_o;
   logic [1:0]           mreqhpl_o;
   logic [C_ADDR_SZ-1:0] mreqaddr_o;
   logic [W-1:0]         mreqdata_o;
   logic                 mrspready_o;
   logic                 mrspvalid_i;
   logic                 mrsprerr_i;
   logic                 mrspwerr_i;
   logic [W-1:0]         mrspdata_i;

   modport slave (
      output ireqready_o, irspvalid_o, irsprerr_o, irspdata_o,
      input  ireqvalid_i, ireqhpl_i, ireqaddr_i, irspready_i,
      output dreqready_o, drspvalid_o, drsprerr_o, drspwerr_o, drspdata_o,
      input  dreqvalid_i, dreqsize_i, dreqdvalid_i, dreqhpl_i, dreqaddr_i, dreqdata_i, drspready_i,
      output mreqvalid_o, mreqsrc_o, mreqsize_o, mreqdvalid_o, mreqhpl_o, mreqaddr_o, mreqdata_o, mrspready_o,
      input  mreqready_i, mrspvalid_i, mrsprerr_i, mrspwerr_i, mrspdata_i
   );

   modport master (
      input  ireqready_o, irspvalid_o, irsprerr_o, irspdata_o,
      output ireqvalid_i, ireqhpl_i, ireqaddr_i, irspready_i,
      input  dreqready_o, drspvalid_o, drsprerr_o, drspwerr_o, drspdata_o,
      output dreqvalid_i, dreqsize_i, dreqdvalid_i, dreqhpl_i, dreqaddr_i, dreqdata_i, drspready_i,
      input  mreqvalid_o, mreqsrc_o, mreqsize_o, mreqdvalid_o, mreqhpl_o, mreqaddr_o, mreqdata_o, mrspready_o,
      output mreqready_i, mrspvalid_i, mrsprerr_i, mrspwerr_i, mrspdata_i
   );

endinterface

// File: rtl/merlin_route_fifo.sv
// In-order 1-bit route FIFO: remembers which port issued each outstanding
// memory request so responses can be steered back.
module merlin_route_fifo
   import merlin_mem_arbiter_pkg::*;
#(
   parameter int C_DEPTH_X = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic i_push,
   input  logic i_din,
   input  logic i_pop,
   output logic o_full,
   output logic o_empty,
   output logic o_head
);
   localparam int DEPTH = 1 << C_DEPTH_X;
   localparam logic [C_DEPTH_X:0]   CNT_FULL = (C_DEPTH_X+1)'(DEPTH);
   localparam logic [C_DEPTH_X:0]   CNT_ONE  = (C_DEPTH_X+1)'(1);
   localparam logic [C_DEPTH_X-1:0] PTR_ONE  = (C_DEPTH_X)'(1);

   logic [DEPTH-1:0]     r_mem;
   logic [C_DEPTH_X-1:0] r_wptr;
   logic [C_DEPTH_X-1:0] r_rptr;
   logic [C_DEPTH_X:0]   r_count;
   logic                 w_push;
   logic                 w_pop;

   assign o_full  = (r_count == CNT_FULL);
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   // Storage, wrapping pointers and occupancy count.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_mem   <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_din;
            r_wptr        <= r_wptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/merlin_mem_arbiter.sv
// Merges instruction and data ports onto one memory port; round-robin by
// default, fixed data priority when MERLIN_ARB_DPRIO_EN is defined.
module merlin_mem_arbiter
   import merlin_mem_arbiter_pkg::*;
#(
   parameter int C_BUS_SZX      = 5,
   parameter int C_ADDR_SZ      = 32,
   parameter int C_OSTD_DEPTH_X = 2
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   merlin_mem_arbiter_if.slave  bus
);
   localparam logic [1:0] ISIZE = 2'(C_BUS_SZX - 3);

   arb_state_e r_state;
   arb_state_e w_state_nxt;
   logic       r_gnt;
   logic       w_gnt;
   logic       w_gnt_valid;
   logic       w_mvalid;
   logic       w_acc;
   logic       w_full;
   logic       w_empty;
   logic       w_head;
   logic       w_pop;
`ifndef MERLIN_ARB_DPRIO_EN
   logic       r_last;
`endif

   // Grant selection: a stalled grant is held, otherwise single requester or tie-break.
   always_comb begin
      w_gnt = SRC_I;
      if (r_state == ST_LOCKED) begin
         w_gnt = r_gnt;
      end else if (bus.ireqvalid_i && bus.dreqvalid_i) begin
`ifdef MERLIN_ARB_DPRIO_EN
         w_gnt = SRC_D;
`else
         w_gnt = ~r_last;
`endif
      end else if (bus.dreqvalid_i) begin
         w_gnt = SRC_D;
      end else begin
         w_gnt = SRC_I;
      end
   end

   assign w_gnt_valid     = (w_gnt == SRC_D) ? bus.dreqvalid_i : bus.ireqvalid_i;
   assign w_mvalid        = w_gnt_valid & ~w_full;
   assign w_acc           = w_mvalid & bus.mreqready_i;
   assign bus.ireqready_o = w_acc & (w_gnt == SRC_I);
   assign bus.dreqready_o = w_acc & (w_gnt == SRC_D);

   // Lock next-state: a full FIFO freezes the lock, a stalled request sets it.
   always_comb begin
      w_state_nxt = r_state;
      if (w_full) begin
         w_state_nxt = r_state;
      end else if (w_mvalid && !bus.mreqready_i) begin
         w_state_nxt = ST_LOCKED;
      end else begin
         w_state_nxt = ST_FREE;
      end
   end

   // Lock state, held grant and last accepted source.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= ST_FREE;
         r_gnt   <= SRC_I;
`ifndef MERLIN_ARB_DPRIO_EN
         r_last  <= SRC_D;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt;
`ifndef MERLIN_ARB_DPRIO_EN
         if (w_acc) begin
            r_last <= w_gnt;
         end else begin
            r_last <= r_last;
         end
`endif
      end
   end

   // Memory request fields; an instruction fetch is always a full-word read.
   always_comb begin
      bus.mreqvalid_o  = w_mvalid;
      bus.mreqsrc_o    = SRC_I;
      bus.mreqsize_o   = 2'b00;
      bus.mreqdvalid_o = 1'b0;
      bus.mreqhpl_o    = 2'b00;
      bus.mreqaddr_o   = '0;
      bus.mreqdata_o   = '0;
      if (w_mvalid && (w_gnt == SRC_D)) begin
         bus.mreqsrc_o    = SRC_D;
         bus.mreqsize_o   = bus.dreqsize_i;
         bus.mreqdvalid_o = bus.dreqdvalid_i;
         bus.mreqhpl_o    = bus.dreqhpl_i;
         bus.mreqaddr_o   = bus.dreqaddr_i;
         bus.mreqdata_o   = bus.dreqdata_i;
      end else if (w_mvalid) begin
         bus.mreqsize_o   = ISIZE;
         bus.mreqhpl_o    = bus.ireqhpl_i;
         bus.mreqaddr_o   = bus.ireqaddr_i;
      end else begin
         bus.mreqsrc_o    = SRC_I;
      end
   end

   // Response steering by FIFO head; unsolicited responses are never accepted.
   always_comb begin
      bus.mrspready_o = 1'b0;
      bus.irspvalid_o = 1'b0;
      bus.irsprerr_o  = 1'b0;
      bus.drspvalid_o = 1'b0;
      bus.drsprerr_o  = 1'b0;
      bus.drspwerr_o  = 1'b0;
      if (!w_empty && (w_head == SRC_D)) begin
         bus.mrspready_o = bus.drspready_i;
         bus.drspvalid_o = bus.mrspvalid_i;
         bus.drsprerr_o  = bus.mrsprerr_i;
         bus.drspwerr_o  = bus.mrspwerr_i;
      end else if (!w_empty) begin
         bus.mrspready_o = bus.irspready_i;
         bus.irspvalid_o = bus.mrspvalid_i;
         bus.irsprerr_o  = bus.mrsprerr_i;
      end else begin
         bus.mrspready_o = 1'b0;
      end
   end

   assign bus.irspdata_o = bus.mrspdata_i;
   assign bus.drspdata_o = bus.mrspdata_i;
   assign w_pop          = bus.mrspvalid_i & bus.mrspready_o;

   merlin_route_fifo #(
      .C_DEPTH_X (C_OSTD_DEPTH_X)
   ) u_route_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .i_push  (w_acc),
      .i_din   (w_gnt),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

endmodule

// File: tb/tb_merlin_mem_arbiter.sv
// Bench for merlin_mem_arbiter: vector table, directed multi-cycle sequences
// and a randomized run against a queue-based reference model.
module tb_merlin_mem_arbiter;
   import merlin_mem_arbiter_pkg::*;

   localparam int SZX   = 5;
   localparam int A     = 32;
   localparam int X     = 2;
   localparam int DEPTH = 4;
   localparam int W     = 32;
   localparam logic [1:0] ISZ = 2'(SZX - 3);
`ifdef MERLIN_ARB_DPRIO_EN
   localparam logic DP = 1'b1;
`else
   localparam logic DP = 1'b0;
`endif

   typedef struct packed {
      logic         mv;
      logic         src;
      logic [1:0]   size;
      logic         dw;
      logic [1:0]   hpl;
      logic [A-1:0] addr;
      logic [W-1:0] data;
      logic         ir;
      logic         dr;
      logic         mrr;
      logic         irv;
      logic         irerr;
      logic         drv;
      logic         drerr;
      logic         dwerr;
      logic [W-1:0] irdata;
      logic [W-1:0] drdata;
   } out_t;

   typedef struct {
      logic iv, dv, mrdy, rv;
      logic e_mv, e_src, e_ir, e_dr, e_mrr, e_irv, e_drv;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_bad = 0;
   vec_t tbl [7];

   merlin_mem_arbiter_if #(.C_BUS_SZX(SZX), .C_ADDR_SZ(A)) bus ();

   merlin_mem_arbiter #(
      .C_BUS_SZX      (SZX),
      .C_ADDR_SZ      (A),
      .C_OSTD_DEPTH_X (X)
   ) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic logic tie(input logic rr);
      return DP ? 1'b1 : rr;
   endfunction

   function automatic out_t sample();
      out_t s;
      s.mv = bus.mreqvalid_o;   s.src = bus.mreqsrc_o;   s.size = bus.mreqsize_o;
      s.dw = bus.mreqdvalid_o;  s.hpl = bus.mreqhpl_o;   s.addr = bus.mreqaddr_o;
      s.data = bus.mreqdata_o;  s.ir = bus.ireqready_o;  s.dr = bus.dreqready_o;
      s.mrr = bus.mrspready_o;  s.irv = bus.irspvalid_o; s.irerr = bus.irsprerr_o;
      s.drv = bus.drspvalid_o;  s.drerr = bus.drsprerr_o; s.dwerr = bus.drspwerr_o;
      s.irdata = bus.irspdata_o; s.drdata = bus.drspdata_o;
      return s;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic cmp(input string nm, input out_t exp, input logic req_care,
                      input logic ierr_care, input logic derr_care);
      out_t act;
      out_t e;
      act = sample();
      e   = exp;
      if (!req_care) begin
         act.src = 1'b0; act.size = 2'b00; act.dw = 1'b0; act.hpl = 2'b00; act.addr = '0; act.data = '0;
         e.src   = 1'b0; e.size   = 2'b00; e.dw   = 1'b0; e.hpl   = 2'b00; e.addr   = '0; e.data   = '0;
      end
      if (!ierr_care) begin
         act.irerr = 1'b0; e.irerr = 1'b0;
      end
      if (!derr_care) begin
         act.drerr = 1'b0; act.dwerr = 1'b0; e.drerr = 1'b0; e.dwerr = 1'b0;
      end
      n_vec++;
      if (act !== e) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.ireqvalid_i = 1'b0; bus.ireqhpl_i = 2'b00; bus.ireqaddr_i = '0; bus.irspready_i = 1'b0;
      bus.dreqvalid_i = 1'b0; bus.dreqsize_i = 2'b00; bus.dreqdvalid_i = 1'b0; bus.dreqhpl_i = 2'b00;
      bus.dreqaddr_i = '0; bus.dreqdata_i = '0; bus.drspready_i = 1'b0;
      bus.mreqready_i = 1'b0; bus.mrspvalid_i = 1'b0; bus.mrsprerr_i = 1'b0;
      bus.mrspwerr_i = 1'b0; bus.mrspdata_i = '0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
   endtask

   task automatic set_row(input int k, input logic iv, input logic dv, input logic mrdy, input logic rv,
                          input logic mv, input logic src, input logic ir, input logic dr,
                          input logic mrr, input logic irv, input logic drv);
      tbl[k] = '{iv, dv, mrdy, rv, mv, src, ir, dr, mrr, irv, drv};
   endtask

   // Reference model state for the randomized run.
   logic         rq [$];
   logic         m_last, m_locked, m_lsrc;
   logic         ip, dp_, dw_;
   logic [1:0]   ih, ds, dh;
   logic [A-1:0] ia, da;
   logic [W-1:0] dd;

   initial begin
      out_t e;
      logic [6:0] got, want;
      rst = 1'b1;
      idle();
      #12;
      rst = 1'b0;
      tick();
      cmp("reset_outputs", '0, 1'b1, 1'b1, 1'b1);

      // Ties fill the FIFO, full stalls, a pop frees space only on the next cycle.
      set_row(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, tie(1'b0), ~tie(1'b0), tie(1'b0), 1'b0, 1'b0, 1'b0);
      set_row(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, tie(1'b1), ~tie(1'b1), tie(1'b1), 1'b1, 1'b0, 1'b0);
      set_row(2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, tie(1'b0), ~tie(1'b0), tie(1'b0), 1'b1, 1'b0, 1'b0);
      set_row(3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, tie(1'b1), ~tie(1'b1), tie(1'b1), 1'b1, 1'b0, 1'b0);
      set_row(4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      set_row(5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ~tie(1'b0), tie(1'b0));
      set_row(6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, tie(1'b0), ~tie(1'b0), tie(1'b0), 1'b1, 1'b0, 1'b0);
      bus.irspready_i = 1'b1;
      bus.drspready_i = 1'b1;
      for (int k = 0; k < 7; k++) begin
         bus.ireqvalid_i = tbl[k].iv;  bus.dreqvalid_i = tbl[k].dv;
         bus.mreqready_i = tbl[k].mrdy; bus.mrspvalid_i = tbl[k].rv;
         #2;
         got  = {bus.mreqvalid_o, bus.mreqsrc_o & tbl[k].e_mv, bus.ireqready_o, bus.dreqready_o,
                 bus.mrspready_o, bus.irspvalid_o, bus.drspvalid_o};
         want = {tbl[k].e_mv, tbl[k].e_src & tbl[k].e_mv, tbl[k].e_ir, tbl[k].e_dr,
                 tbl[k].e_mrr, tbl[k].e_irv, tbl[k].e_drv};
         chk($sformatf("tbl_row%0d", k), 32'(got), 32'(want));
         tick();
      end

      // Stalled data write holds its grant and fields while the fetch rises.
      do_reset();
      bus.dreqvalid_i = 1'b1; bus.dreqdvalid_i = 1'b1; bus.dreqsize_i = 2'b10; bus.dreqhpl_i = 2'b11;
      bus.dreqaddr_i = 32'h0000_0100; bus.dreqdata_i = 32'hDEAD_BEEF; bus.ireqaddr_i = 32'h0000_0200;
      for (int c = 0; c < 3; c++) begin
         bus.ireqvalid_i = (c > 0) ? 1'b1 : 1'b0;
         #1;
         chk($sformatf("lock_mv_c%0d", c), 32'(bus.mreqvalid_o), 32'd1);
         chk($sformatf("lock_src_c%0d", c), 32'(bus.mreqsrc_o), 32'd1);
         chk($sformatf("lock_addr_c%0d", c), 32'(bus.mreqaddr_o), 32'h0000_0100);
         chk($sformatf("lock_data_c%0d", c), 32'(bus.mreqdata_o), 32'hDEAD_BEEF);
         chk($sformatf("lock_rdy_c%0d", c), 32'({bus.ireqready_o, bus.dreqready_o}), 32'd0);
         tick();
      end
      bus.mreqready_i = 1'b1;
      #1;
      chk("lock_accept_src", 32'(bus.mreqsrc_o), 32'd1);
      chk("lock_accept_rdy", 32'({bus.ireqready_o, bus.dreqready_o}), 32'b01);
      tick();
      bus.dreqvalid_i = 1'b0;
      #1;
      chk("after_lock_src", 32'(bus.mreqsrc_o), 32'd0);
      chk("ifetch_fields", 32'({bus.mreqsize_o, bus.mreqdvalid_o, bus.ireqready_o}), 32'({ISZ, 1'b0, 1'b1}));
      chk("ifetch_wdata", 32'(bus.mreqdata_o), 32'd0);
      chk("ifetch_addr", 32'(bus.mreqaddr_o), 32'h0000_0200);
      tick();

      // Responses I, D, I are routed in order; drspready_i low stalls the memory.
      do_reset();
      bus.mreqready_i = 1'b1;
      bus.ireqvalid_i = 1'b1; #1; chk("acc_i0", 32'(bus.ireqready_o), 32'd1); tick();
      bus.ireqvalid_i = 1'b0; bus.dreqvalid_i = 1'b1; #1; chk("acc_d1", 32'(bus.dreqready_o), 32'd1); tick();
      bus.dreqvalid_i = 1'b0; bus.ireqvalid_i = 1'b1; #1; chk("acc_i2", 32'(bus.ireqready_o), 32'd1); tick();
      bus.ireqvalid_i = 1'b0;
      bus.irspready_i = 1'b1; bus.drspready_i = 1'b1; bus.mrspvalid_i = 1'b1; bus.mrspdata_i = 32'h11;
      #1;
      chk("rsp0_route", 32'({bus.irspvalid_o, bus.drspvalid_o, bus.mrspready_o}), 32'b101);
      chk("rsp0_data", 32'(bus.irspdata_o), 32'h11);
      tick();
      bus.mrspdata_i = 32'h22; bus.mrspwerr_i = 1'b1; bus.drspready_i = 1'b0;
      #1;
      chk("rsp1_stall", 32'({bus.irspvalid_o, bus.drspvalid_o, bus.mrspready_o}), 32'b010);
      chk("rsp1_werr", 32'(bus.drspwerr_o), 32'd1);
      chk("rsp1_data", 32'(bus.drspdata_o), 32'h22);
      tick();
      bus.drspready_i = 1'b1;
      #1;
      chk("rsp1_go", 32'({bus.irspvalid_o, bus.drspvalid_o, bus.mrspready_o}), 32'b011);
      tick();
      bus.mrspdata_i = 32'h33; bus.mrspwerr_i = 1'b0;
      #1;
      chk("rsp2_route", 32'({bus.irspvalid_o, bus.drspvalid_o, bus.mrspready_o}), 32'b101);
      chk("rsp2_data", 32'(bus.irspdata_o), 32'h33);
      tick();
      #1;
      chk("unsolicited", 32'({bus.irspvalid_o, bus.drspvalid_o, bus.mrspready_o}), 32'b000);
      tick();

      // Reset with two requests outstanding flushes the FIFO.
      do_reset();
      bus.mreqready_i = 1'b1;
      bus.ireqvalid_i = 1'b1; tick();
      bus.ireqvalid_i = 1'b0; bus.dreqvalid_i = 1'b1; tick();
      do_reset();
      cmp("midflight_reset", '0, 1'b1, 1'b1, 1'b1);
      bus.ireqvalid_i = 1'b1; bus.dreqvalid_i = 1'b1; bus.mreqready_i = 1'b1;
      bus.mrspvalid_i = 1'b1; bus.irspready_i = 1'b1; bus.drspready_i = 1'b1;
      #1;
      chk("post_reset_grant", 32'({bus.mreqvalid_o, bus.mreqsrc_o}), 32'({1'b1, tie(1'b0)}));
      chk("post_reset_empty", 32'(bus.mrspready_o), 32'd0);
      tick();

      // Randomized traffic against the queue model.
      do_reset();
      rq.delete();
      m_last = SRC_D; m_locked = 1'b0; m_lsrc = SRC_I;
      ip = 1'b0; dp_ = 1'b0;
      ih = 2'b00; ia = '0; ds = 2'b00; dw_ = 1'b0; dh = 2'b00; da = '0; dd = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         logic sel, full, empty, mv, acc, ri, rd;
         if (!ip && ($urandom_range(0, 2) == 0)) begin
            ip = 1'b1; ia = $urandom; ih = 2'($urandom_range(0, 3));
         end
         if (!dp_ && ($urandom_range(0, 2) == 0)) begin
            dp_ = 1'b1; da = $urandom; dd = $urandom; ds = 2'($urandom_range(0, 3));
            dh = 2'($urandom_range(0, 3)); dw_ = 1'($urandom_range(0, 1));
         end
         bus.ireqvalid_i = ip; bus.ireqaddr_i = ia; bus.ireqhpl_i = ih;
         bus.dreqvalid_i = dp_; bus.dreqaddr_i = da; bus.dreqdata_i = dd;
         bus.dreqsize_i = ds; bus.dreqhpl_i = dh; bus.dreqdvalid_i = dw_;
         bus.mreqready_i = ($urandom_range(0, 3) != 0);
         bus.mrspvalid_i = 1'($urandom_range(0, 1));
         bus.irspready_i = ($urandom_range(0, 3) != 0);
         bus.drspready_i = ($urandom_range(0, 3) != 0);
         bus.mrsprerr_i = 1'($urandom_range(0, 1));
         bus.mrspwerr_i = 1'($urandom_range(0, 1));
         bus.mrspdata_i = $urandom;
         #2;
         full  = (rq.size() == DEPTH);
         empty = (rq.size() == 0);
         if (m_locked)     sel = m_lsrc;
         else if (ip && dp_) sel = DP ? SRC_D : ~m_last;
         else              sel = dp_ ? SRC_D : SRC_I;
         mv  = (sel ? dp_ : ip) & ~full;
         acc = mv & bus.mreqready_i;
         ri  = !empty && (rq[0] == SRC_I);
         rd  = !empty && (rq[0] == SRC_D);
         e = '0;
         e.mv = mv;
         if (sel) begin
            e.src = 1'b1; e.size = ds; e.dw = dw_; e.hpl = dh; e.addr = da; e.data = dd;
         end else begin
            e.src = 1'b0; e.size = ISZ; e.dw = 1'b0; e.hpl = ih; e.addr = ia; e.data = '0;
         end
         e.ir = acc & ~sel;
         e.dr = acc & sel;
         e.mrr = ri ? bus.irspready_i : (rd ? bus.drspready_i : 1'b0);
         e.irv = ri & bus.mrspvalid_i;
         e.drv = rd & bus.mrspvalid_i;
         e.irerr = bus.mrsprerr_i;
         e.drerr = bus.mrsprerr_i;
         e.dwerr = bus.mrspwerr_i;
         e.irdata = bus.mrspdata_i;
         e.drdata = bus.mrspdata_i;
         cmp($sformatf("rand_c%0d", cyc), e, mv, ri, rd);
         if (bus.mrspvalid_i && e.mrr) void'(rq.pop_front());
         if (acc) begin
            rq.push_back(sel);
            m_last = sel;
            m_locked = 1'b0;
            if (sel) dp_ = 1'b0;
            else     ip = 1'b0;
         end else if (mv) begin
            m_locked = 1'b1;
            m_lsrc = sel;
         end else if (!full) begin
            m_locked = 1'b0;
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
